// File: rtl/led_mode_controller.sv
// -----------------------------------------------------------------------------
// led_mode_controller
//
// Steps one LED through four display modes (OFF, ON, BLINK_SLOW, BLINK_FAST).
// Each press of an active-low push button advances the mode by one. The button
// is synchronised, optionally debounced and then edge-detected inside this
// block. A blink timer produces the LED phase in the two blink modes.
//
// Optional feature macro:
//   LED_MODE_DEBOUNCE_EN  defined   -> debounce counter filters the synchronised
//                                      button level (DEBOUNCE_CYCLES stable cycles)
//                         undefined -> synchronised level is used directly
//
// Parameters:
//   DEBOUNCE_CYCLES   stable cycles needed to accept a new button level
//   SLOW_HALF_CYCLES  half-period of BLINK_SLOW in clock cycles
//   FAST_HALF_CYCLES  half-period of BLINK_FAST in clock cycles (<= SLOW)
//
// Ports:
//   clock         in   system clock, all state on rising edge
//   reset         in   asynchronous, active-high reset
//   button_n      in   asynchronous push button, 0 = pressed
//   led           out  LED drive, 1 = lit
//   mode          out  00 OFF, 01 ON, 10 BLINK_SLOW, 11 BLINK_FAST
//   mode_changed  out  one-cycle pulse in the first cycle mode shows a new value
// -----------------------------------------------------------------------------
module led_mode_controller #(
    parameter int unsigned DEBOUNCE_CYCLES  = 1_000_000,
    parameter int unsigned SLOW_HALF_CYCLES = 25_000_000,
    parameter int unsigned FAST_HALF_CYCLES = 5_000_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       button_n,
    output logic       led,
    output logic [1:0] mode,
    output logic       mode_changed
);

    // -------------------------------------------------------------------------
    // Parameter sanity
    // -------------------------------------------------------------------------
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be >= 1");
    end
    if (FAST_HALF_CYCLES < 1) begin : g_bad_fast_zero
        $error("FAST_HALF_CYCLES must be >= 1");
    end
    if (FAST_HALF_CYCLES > SLOW_HALF_CYCLES) begin : g_bad_fast_slow
        $error("FAST_HALF_CYCLES must not exceed SLOW_HALF_CYCLES");
    end

    // Blink counter is sized for the longer half-period; at least one bit.
    localparam int unsigned CNT_W = (SLOW_HALF_CYCLES > 1) ? $clog2(SLOW_HALF_CYCLES) : 1;
    localparam logic [CNT_W-1:0] SLOW_LAST = CNT_W'(SLOW_HALF_CYCLES - 1);
    localparam logic [CNT_W-1:0] FAST_LAST = CNT_W'(FAST_HALF_CYCLES - 1);

    typedef enum logic [1:0] {
        StOff       = 2'b00,
        StOn        = 2'b01,
        StBlinkSlow = 2'b10,
        StBlinkFast = 2'b11
    } state_e;

    // -------------------------------------------------------------------------
    // Input synchroniser and press detection
    // -------------------------------------------------------------------------
    logic r_sync1;
    logic r_sync2;
    logic r_vld1;
    logic r_vld2;
    logic r_armed;
    logic r_stable_prev;
    logic r_press;
    logic w_stable;

    // r_vld* mark when r_sync2 holds a real sample rather than its reset value.
    // r_armed is set once the button has actually been seen released after
    // reset, so a button still held through reset never counts as a press.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sync1       <= 1'b1;
            r_sync2       <= 1'b1;
            r_vld1        <= 1'b0;
            r_vld2        <= 1'b0;
            r_armed       <= 1'b0;
            r_stable_prev <= 1'b1;
            r_press       <= 1'b0;
        end else begin
            r_sync1       <= button_n;
            r_sync2       <= r_sync1;
            r_vld1        <= 1'b1;
            r_vld2        <= r_vld1;
            if (r_vld2 && r_sync2) begin
                r_armed <= 1'b1;
            end
            r_stable_prev <= w_stable;
            r_press       <= r_armed && r_stable_prev && !w_stable;
        end
    end

    // -------------------------------------------------------------------------
    // Stable button level
    // -------------------------------------------------------------------------
`ifdef LED_MODE_DEBOUNCE_EN
    localparam int unsigned DEB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

    logic             r_stable;
    logic [DEB_W-1:0] r_deb_cnt;

    // Counts consecutive cycles where the synchronised level disagrees with the
    // accepted level; any agreement restarts the count, so short glitches die.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_stable  <= 1'b1;
            r_deb_cnt <= '0;
        end else if (r_sync2 == r_stable) begin
            r_deb_cnt <= '0;
        end else if (r_deb_cnt == DEB_LAST) begin
            r_stable  <= r_sync2;
            r_deb_cnt <= '0;
        end else begin
            r_deb_cnt <= r_deb_cnt + 1'b1;
        end
    end

    assign w_stable = r_stable;
`else
    assign w_stable = r_sync2;
`endif

    // -------------------------------------------------------------------------
    // Mode FSM and blink timer
    // -------------------------------------------------------------------------
    state_e           r_state;
    logic             r_changed;
    logic [CNT_W-1:0] r_blink_cnt;
    logic             r_phase;
    logic [CNT_W-1:0] w_half_last;

    assign w_half_last = (r_state == StBlinkFast) ? FAST_LAST : SLOW_LAST;

    // A press takes priority over a timer wrap: the new mode always starts with
    // a cleared counter and the LED lit for a full half-period.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= StOff;
            r_changed   <= 1'b0;
            r_blink_cnt <= '0;
            r_phase     <= 1'b1;
        end else if (r_press) begin
            case (r_state)
                StOff:       r_state <= StOn;
                StOn:        r_state <= StBlinkSlow;
                StBlinkSlow: r_state <= StBlinkFast;
                default:     r_state <= StOff;
            endcase
            r_changed   <= 1'b1;
            r_blink_cnt <= '0;
            r_phase     <= 1'b1;
        end else begin
            r_changed <= 1'b0;
            if (r_state == StBlinkSlow || r_state == StBlinkFast) begin
                if (r_blink_cnt == w_half_last) begin
                    r_blink_cnt <= '0;
                    r_phase     <= ~r_phase;
                end else begin
                    r_blink_cnt <= r_blink_cnt + 1'b1;
                end
            end else begin
                r_blink_cnt <= '0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    always_comb begin
        led = 1'b0;
        case (r_state)
            StOff:   led = 1'b0;
            StOn:    led = 1'b1;
            default: led = r_phase;
        endcase
    end

    assign mode         = r_state;
    assign mode_changed = r_changed;

endmodule
